// File: rtl/rtc_bus_pkg.sv
// Shared definitions for the RTC bus responder: FSM encoding, register map
// constants and the BCD stepping helpers used by the timekeeper.
package rtc_bus_pkg;

    localparam int unsigned BUS_W = 8;

    localparam logic [BUS_W-1:0] ADDR_SEC  = 8'h00;
    localparam logic [BUS_W-1:0] ADDR_MIN  = 8'h01;
    localparam logic [BUS_W-1:0] ADDR_HOUR = 8'h02;

    localparam logic [BUS_W-1:0] BCD_MAX_MS = 8'h59;
    localparam logic [BUS_W-1:0] BCD_MAX_HR = 8'h23;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA_WAIT,
        ST_READ,
        ST_WRITE
    } state_t;

    function automatic logic bcd_is_valid(input logic [BUS_W-1:0] v);
        bcd_is_valid = (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
    endfunction

    // Carry out of a register on a tick; corrupt (non-BCD) contents never carry.
    function automatic logic bcd_wrap(input logic [BUS_W-1:0] v, input logic [BUS_W-1:0] lim);
        bcd_wrap = bcd_is_valid(v) && (v >= lim);
    endfunction

    function automatic logic [BUS_W-1:0] bcd_next(input logic [BUS_W-1:0] v, input logic [BUS_W-1:0] lim);
        logic [3:0] hi;
        logic [3:0] lo;
        hi = v[7:4];
        lo = v[3:0];
        if (!bcd_is_valid(v))
            bcd_next = {(hi > 4'd9) ? 4'd0 : hi, (lo > 4'd9) ? 4'd0 : lo};
        else if (v >= lim)
            bcd_next = '0;
        else if (lo == 4'd9)
            bcd_next = {hi + 4'd1, 4'd0};
        else
            bcd_next = {hi, lo + 4'd1};
    endfunction

endpackage

// File: rtl/rtc_bcd_timekeeper.sv
// One-second tick divider driving the BCD seconds/minutes/hours chain, with
// bus writes taking precedence over the tick on the addressed register.
module rtc_bcd_timekeeper
    import rtc_bus_pkg::*;
#(
    parameter int unsigned TICK_DIV = 100_000_000
) (
    input  logic             reloj,
    input  logic             resetM,
    input  logic             we,
    input  logic [BUS_W-1:0] waddr,
    input  logic [BUS_W-1:0] wdata,
    output logic [BUS_W-1:0] sec,
    output logic [BUS_W-1:0] min,
    output logic [BUS_W-1:0] hour
);

    localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [CW-1:0]    cnt;
    logic             tick;
    logic             carry_s;
    logic             carry_m;
    logic [BUS_W-1:0] sec_n;
    logic [BUS_W-1:0] min_n;
    logic [BUS_W-1:0] hour_n;

    assign tick = (cnt == CW'(TICK_DIV - 1));

    always_ff @(posedge reloj or negedge resetM) begin
        if (!resetM)
            cnt <= '0;
        else if (tick)
            cnt <= '0;
        else
            cnt <= cnt + CW'(1);
    end

    // A write to a stage replaces its value and also kills its carry-out.
    always_comb begin
        sec_n   = sec;
        min_n   = min;
        hour_n  = hour;
        carry_s = 1'b0;
        carry_m = 1'b0;
        if (tick) begin
            sec_n   = bcd_next(sec, BCD_MAX_MS);
            carry_s = bcd_wrap(sec, BCD_MAX_MS);
        end
        if (we && waddr == ADDR_SEC) begin
            sec_n   = wdata;
            carry_s = 1'b0;
        end
        if (carry_s) begin
            min_n   = bcd_next(min, BCD_MAX_MS);
            carry_m = bcd_wrap(min, BCD_MAX_MS);
        end
        if (we && waddr == ADDR_MIN) begin
            min_n   = wdata;
            carry_m = 1'b0;
        end
        if (carry_m)
            hour_n = bcd_next(hour, BCD_MAX_HR);
        if (we && waddr == ADDR_HOUR)
            hour_n = wdata;
    end

    always_ff @(posedge reloj or negedge resetM) begin
        if (!resetM) begin
            sec  <= '0;
            min  <= '0;
            hour <= '0;
        end else begin
            sec  <= sec_n;
            min  <= min_n;
            hour <= hour_n;
        end
    end

endmodule

// File: rtl/rtc_bus_responder.sv
// RTC responder on the multiplexed address/data bus: synchronizes the strobes,
// latches addresses, serves reads and accepts writes into a small register file.
module rtc_bus_responder
    import rtc_bus_pkg::*;
#(
    parameter int unsigned NREG        = 16,
    parameter int unsigned TICK_DIV    = 100_000_000,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             reloj,
    input  logic             resetM,
    input  logic             CS,
    input  logic             RD,
    input  logic             WR,
    input  logic             A_D,
    input  logic [BUS_W-1:0] ad_in,
    output logic [BUS_W-1:0] ad_out,
    output logic             ad_oe,
    output logic [BUS_W-1:0] addr_q,
    output logic             wr_pulse,
    output logic             proto_err
);

    localparam int unsigned AW = (NREG > 1) ? $clog2(NREG) : 1;

    logic [3:0]       ctl_sync [SYNC_STAGES];
    logic [BUS_W-1:0] ad_sync  [SYNC_STAGES];
    logic [BUS_W-1:0] gp_regs  [NREG];

    logic             cs_s, rd_s, wr_s, ad_s, wr_d, viol_q;
    logic [BUS_W-1:0] ad_in_s;
    logic             viol, addr_phase, wr_rise, in_range;
    logic             latch_addr, wr_accept, oor_write;
    logic [BUS_W-1:0] rdata, tk_sec, tk_min, tk_hour;
    state_t           state, state_n;

    always_ff @(posedge reloj or negedge resetM) begin
        if (!resetM) begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
                ctl_sync[i] <= '1;
                ad_sync[i]  <= '0;
            end
        end else begin
            ctl_sync[0] <= {CS, RD, WR, A_D};
            ad_sync[0]  <= ad_in;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                ctl_sync[i] <= ctl_sync[i-1];
                ad_sync[i]  <= ad_sync[i-1];
            end
        end
    end

    assign {cs_s, rd_s, wr_s, ad_s} = ctl_sync[SYNC_STAGES-1];
    assign ad_in_s    = ad_sync[SYNC_STAGES-1];
    assign viol       = (!rd_s && !wr_s) || (!rd_s && !ad_s);
    assign addr_phase = !cs_s && !wr_s && !ad_s;
    assign wr_rise    = wr_s && !wr_d;
    assign in_range   = (addr_q < BUS_W'(NREG));

    always_comb begin
        state_n    = state;
        latch_addr = 1'b0;
        wr_accept  = 1'b0;
        oor_write  = 1'b0;
        if (viol) begin
            state_n = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:
                    if (addr_phase) state_n = ST_ADDR;
                ST_ADDR:
                    if (wr_rise) begin
                        latch_addr = 1'b1;
                        state_n    = ST_DATA_WAIT;
                    end else if (cs_s) begin
                        state_n = ST_IDLE;
                    end
                ST_DATA_WAIT:
                    if (!cs_s && !rd_s && ad_s)      state_n = ST_READ;
                    else if (!cs_s && !wr_s && ad_s) state_n = ST_WRITE;
                    else if (addr_phase)             state_n = ST_ADDR;
                ST_READ:
                    if (rd_s || cs_s) state_n = ST_DATA_WAIT;
                ST_WRITE:
                    if (wr_rise) begin
                        wr_accept = in_range;
                        oor_write = !in_range;
                        state_n   = ST_DATA_WAIT;
                    end else if (cs_s) begin
                        state_n = ST_DATA_WAIT;
                    end
                default: state_n = ST_IDLE;
            endcase
        end
    end

    // Registers 0..2 live in the timekeeper; their gp_regs slots are shadowed.
    always_comb begin
        rdata = '0;
        if (addr_q == ADDR_SEC)       rdata = tk_sec;
        else if (addr_q == ADDR_MIN)  rdata = tk_min;
        else if (addr_q == ADDR_HOUR) rdata = tk_hour;
        else if (in_range)            rdata = gp_regs[addr_q[AW-1:0]];
    end

    always_ff @(posedge reloj or negedge resetM) begin
        if (!resetM) begin
            state     <= ST_IDLE;
            wr_d      <= 1'b1;
            viol_q    <= 1'b0;
            addr_q    <= '0;
            ad_oe     <= 1'b0;
            ad_out    <= '0;
            wr_pulse  <= 1'b0;
            proto_err <= 1'b0;
        end else begin
            state     <= state_n;
            wr_d      <= wr_s;
            viol_q    <= viol;
            if (latch_addr) addr_q <= ad_in_s;
            // Output enable follows the next state so it appears on READ entry.
            ad_oe     <= (state_n == ST_READ);
            ad_out    <= (state_n == ST_READ) ? rdata : '0;
            wr_pulse  <= wr_accept;
            proto_err <= (viol && !viol_q) || oor_write;
        end
    end

    always_ff @(posedge reloj or negedge resetM) begin
        if (!resetM) begin
            for (int unsigned i = 0; i < NREG; i++) gp_regs[i] <= '0;
        end else if (wr_accept) begin
            gp_regs[addr_q[AW-1:0]] <= ad_in_s;
        end
    end

    rtc_bcd_timekeeper #(
        .TICK_DIV (TICK_DIV)
    ) u_timekeeper (
        .reloj  (reloj),
        .resetM (resetM),
        .we     (wr_accept),
        .waddr  (addr_q),
        .wdata  (ad_in_s),
        .sec    (tk_sec),
        .min    (tk_min),
        .hour   (tk_hour)
    );

endmodule
